door_ctrl: RTL and testbench

//  Downstream of the elevator FSM. Consumes its door command (0 idle, 1 open, 2 close) and engine code.

---
 rtl/door_ctrl_pkg.sv | 31 +++
 rtl/door_timer.sv | 27 ++
 rtl/door_ctrl.sv | 122 ++++++++++++
 tb/tb_door_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/door_ctrl_pkg.sv
// Shared encodings for the door controller: door commands, motor drive codes,
// engine codes and the door state machine states.
package door_ctrl_pkg;

   localparam logic [1:0] DOOR_IDLE  = 2'd0;
   localparam logic [1:0] DOOR_OPEN  = 2'd1;
   localparam logic [1:0] DOOR_CLOSE = 2'd2;

   localparam logic [1:0] MOT_STOP   = 2'd0;
   localparam logic [1:0] MOT_OPEN   = 2'd1;
   localparam logic [1:0] MOT_CLOSE  = 2'd2;

   localparam logic [1:0] ENG_IDLE   = 2'd0;

   typedef enum logic [2:0] {
      ST_CLOSED  = 3'd0,
      ST_OPENING = 3'd1,
      ST_OPENED  = 3'd2,
      ST_CLOSING = 3'd3,
      ST_FAULT   = 3'd4
   } door_state_t;

   function automatic logic [1:0] motor_of(input door_state_t st);
      case (st)
         ST_OPENING: motor_of = MOT_OPEN;
         ST_CLOSING: motor_of = MOT_CLOSE;
         default:    motor_of = MOT_STOP;
      endcase
   endfunction

endpackage

// File: rtl/door_timer.sv
// Dwell counter: clears on request, counts while enabled, saturates at i_lim.
// o_tc flags that the count has reached the limit.
module door_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_lim,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_en && (r_cnt != i_lim))
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_tc = (r_cnt == i_lim);

endmodule

// File: rtl/door_ctrl.sv
// Elevator door controller: drives the door motor between limit switches,
// reverses on obstruction, and latches a fault on timeouts or interlock breaches.
module door_ctrl
   import door_ctrl_pkg::*;
#(
   parameter int MOVE_TIMEOUT = 200,
   parameter int HOLD_CYCLES  = 100,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] door_cmd,
   input  logic [1:0] engine,
   input  logic       lim_open,
   input  logic       lim_closed,
   input  logic       obstruct,
   input  logic       fault_clr,
   output logic [1:0] motor,
   output logic       door_closed,
   output logic       door_opened,
   output logic       busy,
   output logic       fault
);

   localparam logic [CNT_W-1:0] LIM_MOVE = CNT_W'(MOVE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LIM_HOLD = CNT_W'(HOLD_CYCLES);

   door_state_t      r_state;
   door_state_t      w_next;
   door_state_t      w_state_d;
   door_state_t      w_sw_state;
   logic [1:0]       r_motor;
   logic             r_closed;
   logic             r_opened;
   logic             r_busy;
   logic             r_fault;
   logic             w_tc;
   logic             w_tmr_clr;
   logic             w_tmr_en;
   logic [CNT_W-1:0] w_tmr_lim;

   // Where the door is judged to be from the switches alone; used on reset and fault recovery.
   always_comb begin
      w_sw_state = ST_CLOSING;
      if (lim_closed)
         w_sw_state = ST_CLOSED;
      else if (lim_open)
         w_sw_state = ST_OPENED;
   end

   always_comb begin
      w_next = r_state;
      if (lim_open && lim_closed)
         w_next = ST_FAULT;
      else if ((engine != ENG_IDLE) && (r_state != ST_CLOSED))
         w_next = ST_FAULT;
      else begin
         case (r_state)
            ST_CLOSED:
               if (door_cmd == DOOR_OPEN && engine == ENG_IDLE)
                  w_next = ST_OPENING;
            ST_OPENING:
               if (lim_open)
                  w_next = ST_OPENED;
               else if (w_tc)
                  w_next = ST_FAULT;
            ST_OPENED:
               if (door_cmd == DOOR_CLOSE && w_tc && !obstruct)
                  w_next = ST_CLOSING;
            ST_CLOSING:
               if (obstruct || door_cmd == DOOR_OPEN)
                  w_next = ST_OPENING;
               else if (lim_closed)
                  w_next = ST_CLOSED;
               else if (w_tc)
                  w_next = ST_FAULT;
            ST_FAULT:
               if (fault_clr)
                  w_next = w_sw_state;
            default:
               w_next = ST_FAULT;
         endcase
      end
   end

   always_comb begin
      w_state_d = w_next;
      if (!reset)
         w_state_d = w_sw_state;
   end

   // Timer restarts on every state change; in OPENED it saturates at the hold limit.
   assign w_tmr_clr = (w_next != r_state);
   assign w_tmr_en  = (r_state == ST_OPENING) || (r_state == ST_CLOSING) ||
                      (r_state == ST_OPENED);
   assign w_tmr_lim = (r_state == ST_OPENED) ? LIM_HOLD : LIM_MOVE;

   door_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .i_rst_n (reset),
      .i_clr   (w_tmr_clr),
      .i_en    (w_tmr_en),
      .i_lim   (w_tmr_lim),
      .o_tc    (w_tc)
   );

   always_ff @(posedge clk) begin
      r_state  <= w_state_d;
      r_motor  <= reset ? motor_of(w_state_d) : MOT_STOP;
      r_closed <= (w_state_d == ST_CLOSED);
      r_opened <= (w_state_d == ST_OPENED);
      r_busy   <= (w_state_d == ST_OPENING) || (w_state_d == ST_CLOSING);
      r_fault  <= (w_state_d == ST_FAULT);
   end

   assign motor       = r_motor;
   assign door_closed = r_closed;
   assign door_opened = r_opened;
   assign busy        = r_busy;
   assign fault       = r_fault;

endmodule

// File: tb/tb_door_ctrl.sv
// Door controller bench: directed scenarios plus random traffic, every cycle
// compared against a dwell-time reference model of the door rules.
module tb_door_ctrl;

   localparam int MT   = 8;
   localparam int HOLD = 4;

   localparam int M_CLOSED  = 0;
   localparam int M_OPENING = 1;
   localparam int M_OPENED  = 2;
   localparam int M_CLOSING = 3;
   localparam int M_FAULT   = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] door_cmd = 2'd0;
   logic [1:0] engine = 2'd0;
   logic       lim_open = 1'b0;
   logic       lim_closed = 1'b0;
   logic       obstruct = 1'b0;
   logic       fault_clr = 1'b0;
   logic [1:0] motor;
   logic       door_closed, door_opened, busy, fault;

   int n_vec = 0;
   int n_err = 0;
   int m_st = M_CLOSED;
   int m_dwell = 0;
   int m_motor = 0;

   door_ctrl #(.MOVE_TIMEOUT(MT), .HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .door_cmd(door_cmd), .engine(engine),
      .lim_open(lim_open), .lim_closed(lim_closed), .obstruct(obstruct),
      .fault_clr(fault_clr), .motor(motor), .door_closed(door_closed),
      .door_opened(door_opened), .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference: door rules in terms of how long the door has dwelt in its current state.
   function automatic int sw_pos();
      if (lim_closed) return M_CLOSED;
      if (lim_open)   return M_OPENED;
      return M_CLOSING;
   endfunction

   function automatic int model_next();
      if (lim_open && lim_closed) return M_FAULT;
      if (engine != 0 && m_st != M_CLOSED) return M_FAULT;
      case (m_st)
         M_CLOSED:  return (door_cmd == 1 && engine == 0) ? M_OPENING : M_CLOSED;
         M_OPENING: begin
            if (lim_open) return M_OPENED;
            if (m_dwell + 1 >= MT) return M_FAULT;
            return M_OPENING;
         end
         M_OPENED:  return (door_cmd == 2 && m_dwell >= HOLD && !obstruct) ? M_CLOSING : M_OPENED;
         M_CLOSING: begin
            if (obstruct || door_cmd == 1) return M_OPENING;
            if (lim_closed) return M_CLOSED;
            if (m_dwell + 1 >= MT) return M_FAULT;
            return M_CLOSING;
         end
         default:   return fault_clr ? sw_pos() : M_FAULT;
      endcase
   endfunction

   task automatic model_step();
      int nx;
      if (!reset) begin
         m_st = sw_pos();
         m_dwell = 0;
         m_motor = 0;
      end else begin
         nx = model_next();
         m_dwell = (nx == m_st) ? m_dwell + 1 : 0;
         m_st = nx;
         m_motor = (m_st == M_OPENING) ? 1 : (m_st == M_CLOSING) ? 2 : 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("motor", int'(motor), m_motor);
      chk("door_closed", int'(door_closed), int'(m_st == M_CLOSED));
      chk("door_opened", int'(door_opened), int'(m_st == M_OPENED));
      chk("busy", int'(busy), int'(m_st == M_OPENING || m_st == M_CLOSING));
      chk("fault", int'(fault), int'(m_st == M_FAULT));
      @(negedge clk);
   endtask

   task automatic idle_in();
      door_cmd = 0; engine = 0; obstruct = 0; fault_clr = 0;
   endtask

   initial begin
      @(negedge clk);
      // 1: reset on closed switch, open, limit reached after 3 cycles
      reset = 0; lim_closed = 1;
      step();
      chk("t1_reset_closed", int'(door_closed), 1);
      chk("t1_reset_motor", int'(motor), 0);
      reset = 1; door_cmd = 1;
      step();
      chk("t1_open_motor", int'(motor), 1);
      chk("t1_open_busy", int'(busy), 1);
      idle_in(); lim_closed = 0;
      step(); step();
      lim_open = 1;
      step();
      chk("t1_opened_motor", int'(motor), 0);
      chk("t1_opened", int'(door_opened), 1);

      // 2: early close dropped, close after hold accepted
      step(); step();
      door_cmd = 2;
      step();
      chk("t2_early_close", int'(motor), 0);
      idle_in();
      step();
      door_cmd = 2; lim_open = 0;
      step();
      chk("t2_close_motor", int'(motor), 2);
      idle_in();
      step();
      lim_closed = 1;
      step();
      chk("t2_closed", int'(door_closed), 1);

      // 3: obstruction beats lim_closed while closing
      door_cmd = 1;
      step();
      idle_in(); lim_closed = 0; lim_open = 1;
      step();
      repeat (HOLD) step();
      door_cmd = 2;
      step();
      chk("t3_closing", int'(motor), 2);
      idle_in(); lim_open = 0; obstruct = 1; lim_closed = 1;
      step();
      chk("t3_reopen_motor", int'(motor), 1);
      chk("t3_not_closed", int'(door_closed), 0);

      // 4: opening timeout, fault sticky, recovery to closed
      idle_in(); lim_closed = 0;
      repeat (MT - 1) step();
      chk("t4_still_opening", int'(motor), 1);
      step();
      chk("t4_fault", int'(fault), 1);
      chk("t4_fault_motor", int'(motor), 0);
      door_cmd = 1;
      step();
      chk("t4_cmd_ignored", int'(fault), 1);
      idle_in(); fault_clr = 1; lim_closed = 1;
      step();
      chk("t4_recover", int'(door_closed), 1);

      // 5: engine interlock
      idle_in(); door_cmd = 1;
      step();
      idle_in(); lim_closed = 0; lim_open = 1;
      step();
      engine = 2;
      step();
      chk("t5_engine_fault", int'(fault), 1);
      idle_in(); fault_clr = 1; lim_open = 0; lim_closed = 1;
      step();
      idle_in(); engine = 2; door_cmd = 1;
      step();
      chk("t5_closed_hold", int'(door_closed), 1);
      chk("t5_closed_motor", int'(motor), 0);

      // 6: reset mid-closing with no switch restarts closing
      idle_in(); door_cmd = 1;
      step();
      idle_in(); lim_closed = 0; lim_open = 1;
      step();
      repeat (HOLD) step();
      door_cmd = 2;
      step();
      idle_in(); lim_open = 0;
      step();
      reset = 0;
      step();
      chk("t6_reset_motor", int'(motor), 0);
      chk("t6_reset_busy", int'(busy), 1);
      reset = 1;
      step();
      chk("t6_resume_close", int'(motor), 2);

      // Random traffic; switches and safety inputs kept sparse so the door makes progress.
      repeat (3000) begin
         door_cmd   = 2'($urandom_range(0, 3));
         engine     = ($urandom_range(0, 99) < 3) ? 2'($urandom_range(1, 2)) : 2'd0;
         lim_open   = ($urandom_range(0, 99) < 15);
         lim_closed = ($urandom_range(0, 99) < 15);
         obstruct   = ($urandom_range(0, 99) < 8);
         fault_clr  = ($urandom_range(0, 99) < 20);
         reset      = ($urandom_range(0, 99) >= 2);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
